// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bundle around the SDRAM port arbiter: video and CPU requester ports plus the controller port.
// slave = arbiter's view, master = requesters'/controller's view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   vid_address;
    logic                vid_read;
    logic                vid_waitrequest;
    logic [DATA_W-1:0]   vid_readdata;
    logic                vid_readdatavalid;

    logic [ADDR_W-1:0]   cpu_address;
    logic                cpu_read;
    logic                cpu_write;
    logic [DATA_W-1:0]   cpu_writedata;
    logic [DATA_W/8-1:0] cpu_byteenable;
    logic                cpu_waitrequest;
    logic [DATA_W-1:0]   cpu_readdata;
    logic                cpu_readdatavalid;

    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic                m_write;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_waitrequest;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_readdatavalid;

    modport slave (
        input  vid_address, vid_read,
        output vid_waitrequest, vid_readdata, vid_readdatavalid,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport master (
        output vid_address, vid_read,
        input  vid_waitrequest, vid_readdata, vid_readdatavalid,
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Video/CPU arbiter for one SDRAM controller: 1-cycle arbitration, commands and returns pass combinationally.
// Non-owner always stalled; owner stalls on controller waitrequest or, for reads, a full return-tag FIFO.
module sdram_port_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int MAX_PEND  = 4,
    parameter int VID_BURST = 8
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    sdram_port_arbiter_if.slave  bus,
    output logic                 err_orphan
);
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND) + 1;
    localparam int STK_W = $clog2(VID_BURST) + 1;
    localparam logic [CNT_W-1:0] PEND_MAX    = CNT_W'(MAX_PEND);
    localparam logic [STK_W-1:0] STREAK_LAST = STK_W'(VID_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } owner_t;

    owner_t              r_owner, w_owner_nxt;
    logic [STK_W-1:0]    r_streak, w_streak_nxt;
    logic [MAX_PEND-1:0] r_tags;
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;

    logic w_cpu_req, w_cpu_rd, w_fifo_full;
    logic w_own_req, w_own_rd, w_accept, w_push, w_pop, w_head_cpu;

    // A simultaneous cpu_read+cpu_write is a write; the read half is ignored.
    always_comb begin
        w_cpu_req   = bus.cpu_read | bus.cpu_write;
        w_cpu_rd    = bus.cpu_read & ~bus.cpu_write;
        w_fifo_full = (r_count == PEND_MAX);
        w_own_req   = 1'b0;
        w_own_rd    = 1'b0;
        case (r_owner)
            S_VID: begin
                w_own_req = bus.vid_read;
                w_own_rd  = bus.vid_read;
            end
            S_CPU: begin
                w_own_req = w_cpu_req;
                w_own_rd  = w_cpu_rd;
            end
            default: ;
        endcase
        w_accept   = w_own_req & ~bus.m_waitrequest & ~(w_own_rd & w_fifo_full);
        w_push     = w_accept & w_own_rd;
        w_pop      = bus.m_readdatavalid & (r_count != '0);
        w_head_cpu = r_tags[r_rd_ptr];
    end

    // m_read is masked while the tag FIFO is full so the controller never takes an untracked read.
    always_comb begin
        bus.m_address       = '0;
        bus.m_read          = 1'b0;
        bus.m_write         = 1'b0;
        bus.m_writedata     = '0;
        bus.m_byteenable    = '0;
        bus.vid_waitrequest = 1'b1;
        bus.cpu_waitrequest = 1'b1;
        case (r_owner)
            S_VID: begin
                bus.m_address       = bus.vid_address;
                bus.m_read          = bus.vid_read & ~w_fifo_full;
                bus.m_byteenable    = '1;
                bus.vid_waitrequest = bus.m_waitrequest | (bus.vid_read & w_fifo_full);
            end
            S_CPU: begin
                bus.m_address       = bus.cpu_address;
                bus.m_read          = w_cpu_rd & ~w_fifo_full;
                bus.m_write         = bus.cpu_write;
                bus.m_writedata     = bus.cpu_writedata;
                bus.m_byteenable    = bus.cpu_byteenable;
                bus.cpu_waitrequest = bus.m_waitrequest | (w_cpu_rd & w_fifo_full);
            end
            default: ;
        endcase
        bus.vid_readdata      = bus.m_readdata;
        bus.cpu_readdata      = bus.m_readdata;
        bus.vid_readdatavalid = w_pop & ~w_head_cpu;
        bus.cpu_readdatavalid = w_pop & w_head_cpu;
    end

    // Video keeps the port until it has used its streak allowance while the CPU is waiting.
    always_comb begin
        w_owner_nxt  = r_owner;
        w_streak_nxt = r_streak;
        case (r_owner)
            S_IDLE: begin
                w_streak_nxt = '0;
                if (bus.vid_read)
                    w_owner_nxt = S_VID;
                else if (w_cpu_req)
                    w_owner_nxt = S_CPU;
            end
            S_VID: begin
                if (w_accept) begin
                    if (bus.vid_read & (~w_cpu_req | (r_streak < STREAK_LAST))) begin
                        w_owner_nxt  = S_VID;
                        w_streak_nxt = (r_streak == STREAK_LAST) ? r_streak : r_streak + STK_W'(1);
                    end else begin
                        w_owner_nxt  = w_cpu_req ? S_CPU : S_IDLE;
                        w_streak_nxt = '0;
                    end
                end else if (!bus.vid_read) begin
                    w_owner_nxt  = S_IDLE;
                    w_streak_nxt = '0;
                end
            end
            S_CPU: begin
                w_streak_nxt = '0;
                if (w_accept) begin
                    if (w_cpu_req & ~bus.vid_read)
                        w_owner_nxt = S_CPU;
                    else if (bus.vid_read)
                        w_owner_nxt = S_VID;
                    else
                        w_owner_nxt = S_IDLE;
                end else if (!w_cpu_req) begin
                    w_owner_nxt = S_IDLE;
                end
            end
            default: begin
                w_owner_nxt  = S_IDLE;
                w_streak_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_owner  <= S_IDLE;
            r_streak <= '0;
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
            if (w_push) begin
                r_tags[r_wr_ptr] <= (r_owner == S_CPU);
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.m_readdatavalid && (r_count == '0))
                r_err <= 1'b1;
        end
    end

    assign err_orphan = r_err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a rule-level model of ownership, acceptance and return routing.
module tb_sdram_port_arbiter;
    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int MAX_PEND  = 4;
    localparam int VID_BURST = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic err_orphan;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND), .VID_BURST(VID_BURST)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .err_orphan    (err_orphan)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=video 2=cpu; tags hold the port of each outstanding read.
    int mdl_own    = 0;
    int mdl_streak = 0;
    bit mdl_tags[$];
    bit exp_orphan = 1'b0;
    bit mdl_vacc   = 1'b0;
    bit mdl_cacc   = 1'b0;
    bit obs_vacc, obs_cacc, obs_vrv, obs_crv;
    int ctrl_cnt   = 0;
    int ret_prob   = 0;
    bit force_rv   = 1'b0;

    task automatic mdl_reset();
        mdl_own    = 0;
        mdl_streak = 0;
        mdl_tags.delete();
        exp_orphan = 1'b0;
        mdl_vacc   = 1'b0;
        mdl_cacc   = 1'b0;
    endtask

    // One clock: drive controller returns, check everything, advance the model, cross the edge.
    task automatic step();
        bit vr, cw, mw, cpu_req, cpu_rd, full, tag, orphan_now;
        logic [DATA_W-1:0] rdat;
        int nxt;
        orphan_now = 1'b0;
        rdat = '0;
        bus.m_readdatavalid = 1'b0;
        if (force_rv || (ctrl_cnt > 0 && $urandom_range(99) < ret_prob)) begin
            bus.m_readdatavalid = 1'b1;
            rdat = DATA_W'($urandom);
        end
        bus.m_readdata = rdat;
        #1;
        vr = bus.vid_read;
        cw = bus.cpu_write;
        mw = bus.m_waitrequest;
        cpu_req = bus.cpu_read | cw;
        cpu_rd  = bus.cpu_read & !cw;
        full    = (mdl_tags.size() >= MAX_PEND);
        mdl_vacc = (mdl_own == 1) && vr && !mw && !full;
        mdl_cacc = (mdl_own == 2) && cpu_req && !mw && !(cpu_rd && full);
        obs_vacc = vr && !bus.vid_waitrequest;
        obs_cacc = cpu_req && !bus.cpu_waitrequest;
        obs_vrv  = bus.vid_readdatavalid;
        obs_crv  = bus.cpu_readdatavalid;

        chk("vid_wait", bus.vid_waitrequest, !((mdl_own == 1) && !mw && !(vr && full)));
        chk("cpu_wait", bus.cpu_waitrequest, !((mdl_own == 2) && !mw && !(cpu_rd && full)));
        chk("m_read",  bus.m_read,  ((mdl_own == 1) && vr && !full) || ((mdl_own == 2) && cpu_rd && !full));
        chk("m_write", bus.m_write, (mdl_own == 2) && cw);
        if (mdl_own == 1 && vr)      chk("m_addr_vid", bus.m_address, bus.vid_address);
        if (mdl_own == 2 && cpu_req) chk("m_addr_cpu", bus.m_address, bus.cpu_address);
        if (mdl_own == 2 && cw) begin
            chk("m_wdata", bus.m_writedata, bus.cpu_writedata);
            chk("m_be",    bus.m_byteenable, bus.cpu_byteenable);
        end

        if (bus.m_readdatavalid && mdl_tags.size() > 0) begin
            tag = mdl_tags.pop_front();
            chk("vid_rvalid", obs_vrv, !tag);
            chk("cpu_rvalid", obs_crv, tag);
            chk("rdata", tag ? bus.cpu_readdata : bus.vid_readdata, rdat);
        end else begin
            chk("vid_rvalid_idle", obs_vrv, 0);
            chk("cpu_rvalid_idle", obs_crv, 0);
            orphan_now = bus.m_readdatavalid;
        end
        chk("err_orphan", err_orphan, exp_orphan);

        nxt = mdl_own;
        case (mdl_own)
            0: nxt = vr ? 1 : (cpu_req ? 2 : 0);
            1: begin
                if (mdl_vacc) begin
                    if (vr && (!cpu_req || mdl_streak < VID_BURST - 1)) begin
                        nxt = 1;
                        if (mdl_streak < VID_BURST - 1) mdl_streak++;
                    end else begin
                        nxt = cpu_req ? 2 : 0;
                        mdl_streak = 0;
                    end
                end else if (!vr) begin
                    nxt = 0;
                    mdl_streak = 0;
                end
            end
            default: begin
                mdl_streak = 0;
                if (mdl_cacc) nxt = (cpu_req && !vr) ? 2 : (vr ? 1 : 0);
                else          nxt = cpu_req ? 2 : 0;
            end
        endcase
        if (mdl_vacc)           mdl_tags.push_back(1'b0);
        if (mdl_cacc && cpu_rd) mdl_tags.push_back(1'b1);
        mdl_own = nxt;

        if (bus.m_read && !mw) ctrl_cnt++;
        if (bus.m_readdatavalid && ctrl_cnt > 0) ctrl_cnt--;
        @(posedge clk);
        #1;
        if (orphan_now) exp_orphan = 1'b1;
    endtask

    task automatic wait_acc(input int which, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = (which == 1) ? obs_vacc : obs_cacc;
        end
        chk(tag, got, 1);
    endtask

    task automatic rand_inputs();
        int r;
        if (mdl_vacc || !bus.vid_read) begin
            bus.vid_read    = ($urandom_range(99) < 60);
            bus.vid_address = ADDR_W'($urandom);
        end else if ($urandom_range(99) < 3) begin
            bus.vid_read = 1'b0;
        end
        if (mdl_cacc || !(bus.cpu_read || bus.cpu_write)) begin
            r = $urandom_range(9);
            bus.cpu_read       = (r >= 4 && r <= 6) || r == 9;
            bus.cpu_write      = (r >= 7);
            bus.cpu_address    = ADDR_W'($urandom);
            bus.cpu_writedata  = DATA_W'($urandom);
            bus.cpu_byteenable = 2'($urandom);
        end else if ($urandom_range(99) < 3) begin
            bus.cpu_read  = 1'b0;
            bus.cpu_write = 1'b0;
        end
        bus.m_waitrequest = ($urandom_range(99) < 25);
    endtask

    task automatic drain();
        bus.vid_read = 1'b0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.m_waitrequest = 1'b0;
        ret_prob = 100;
        repeat (10) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq, route, exp_seq;
        logic [ADDR_W-1:0] hold_addr;
        rst_n = 1'b0;
        bus.vid_address = '0; bus.vid_read = 1'b1;
        bus.cpu_address = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b1;
        bus.cpu_writedata = '0; bus.cpu_byteenable = '0;
        bus.m_waitrequest = 1'b0; bus.m_readdata = '0; bus.m_readdatavalid = 1'b0;
        mdl_reset();

        // Reset with requests pending
        #12;
        chk("rst_vid_wait", bus.vid_waitrequest, 1);
        chk("rst_cpu_wait", bus.cpu_waitrequest, 1);
        chk("rst_m_read",   bus.m_read, 0);
        chk("rst_m_write",  bus.m_write, 0);
        chk("rst_err",      err_orphan, 0);
        chk("rst_vid_rv",   bus.vid_readdatavalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: 8 video accepts then one CPU write, repeating
        bus.cpu_address = 24'h123456; bus.cpu_writedata = 16'hBEEF; bus.cpu_byteenable = 2'b11;
        bus.vid_address = 24'h000100;
        ret_prob = 100;
        for (int i = 0; i < 28; i++) begin
            step();
            seq = obs_vacc ? 1 : (obs_cacc ? 2 : 0);
            exp_seq = (i == 0) ? 0 : (((i - 1) % 9 == 8) ? 2 : 1);
            chk("contention", seq, exp_seq);
        end
        drain();

        // Return routing: vid A, cpu B, vid C, then three returns
        ret_prob = 0;
        bus.vid_read = 1'b1; bus.vid_address = 24'h00A000;
        wait_acc(1, "acc_A");
        bus.vid_read = 1'b0; bus.cpu_read = 1'b1; bus.cpu_address = 24'h00B000;
        wait_acc(2, "acc_B");
        bus.cpu_read = 1'b0; bus.vid_read = 1'b1; bus.vid_address = 24'h00C000;
        wait_acc(1, "acc_C");
        bus.vid_read = 1'b0;
        repeat (2) step();
        ret_prob = 100;
        for (int k = 0; k < 3; k++) begin
            step();
            route = obs_vrv ? 1 : (obs_crv ? 2 : 0);
            chk("route", route, (k == 1) ? 2 : 1);
        end
        drain();

        // Tag FIFO full
        ret_prob = 0;
        bus.cpu_read = 1'b1;
        for (int n = 0; n < MAX_PEND; n++) begin
            bus.cpu_address = ADDR_W'($urandom);
            wait_acc(2, "fill");
        end
        bus.cpu_address = 24'h0F0F0F;
        repeat (3) begin
            step();
            chk("full_stall", obs_cacc, 0);
        end
        bus.cpu_write = 1'b1; bus.cpu_writedata = 16'h5A5A;
        step();
        chk("full_write", obs_cacc, 1);
        bus.cpu_write = 1'b0;
        ret_prob = 100;
        step();
        chk("pop_cycle_stall", obs_cacc, 0);
        ret_prob = 0;
        step();
        chk("read_after_pop", obs_cacc, 1);
        drain();

        // Backpressure from the controller
        hold_addr = 24'h3C3C3C;
        bus.m_waitrequest = 1'b1; bus.vid_read = 1'b1; bus.vid_address = hold_addr;
        ret_prob = 0;
        step();
        repeat (5) begin
            step();
            chk("bp_no_acc", obs_vacc, 0);
            chk("bp_m_read", bus.m_read, 1);
            chk("bp_m_addr", bus.m_address, hold_addr);
        end
        bus.m_waitrequest = 1'b0;
        step();
        chk("bp_release", obs_vacc, 1);
        drain();

        // Random traffic
        ret_prob = 40;
        repeat (3000) begin
            rand_inputs();
            step();
        end
        drain();
        drain();

        // Orphan return
        force_rv = 1'b1;
        step();
        force_rv = 1'b0;
        chk("orphan_no_vid", obs_vrv, 0);
        chk("orphan_no_cpu", obs_crv, 0);
        repeat (3) step();
        chk("orphan_sticky", err_orphan, 1);

        // Reset with a read in flight
        ret_prob = 0;
        bus.vid_read = 1'b1; bus.vid_address = 24'h777777;
        wait_acc(1, "pre_rst");
        bus.vid_read = 1'b0;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst_err_clr", err_orphan, 0);
        chk("rst_m_read2", bus.m_read, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ret_prob = 100;
        step();
        step();
        chk("rst_inflight_orphan", err_orphan, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
